// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU constants: mult/div control sub-states,
// divider counter limits and the datapath word type.
package mips_alu_pkg;

   typedef logic [31:0] word_t;

   localparam logic [5:0] MULT_IDLE = 6'd0;
   localparam logic [5:0] MULT_INIT = 6'd1;
   localparam logic [5:0] MULT_WORK = 6'd2;

   localparam logic [5:0] DIV_IDLE = 6'd0;
   localparam logic [5:0] DIV_INIT = 6'd1;
   localparam logic [5:0] DIV_WORK = 6'd2;

   localparam logic [5:0] DIV_ITER = 6'd32;
   localparam logic [5:0] DIV_DONE = 6'd33;

endpackage

// File: rtl/division_if.sv
// Control-unit <-> divider bundle: sub-state and operands in,
// quotient/remainder, status and iteration count out.
interface division_if;
   import mips_alu_pkg::*;

   logic [5:0] state;
   word_t      lhs;
   word_t      rhs;
   word_t      quotient;
   word_t      remainder;
   logic       endSignal;
   logic       divZero;
   logic [5:0] counter;

   modport master (
      output state, lhs, rhs,
      input  quotient, remainder, endSignal, divZero, counter
   );

   modport slave (
      input  state, lhs, rhs,
      output quotient, remainder, endSignal, divZero, counter
   );

endinterface

// File: rtl/div_sign_adjust.sv
// Conditional two's complement: abs() of operands and
// negation of the final quotient/remainder.
module div_sign_adjust
   import mips_alu_pkg::*;
(
   input  word_t val,
   input  logic  neg,
   output word_t res
);

   assign res = neg ? (~val + 32'd1) : val;

endmodule

// File: rtl/division.sv
// 32-bit restoring shift-subtract divider (LO=quotient, HI=remainder).
// Define DIVISION_SIGNED_EN for signed div; default build is divu.
module division
   import mips_alu_pkg::*;
(
   input  logic Clk,
   input  logic reset,
   division_if.slave bus
);

   word_t      quot;
   word_t      rem;
   word_t      dvd;
   word_t      dvs;
   logic [5:0] cnt;
   logic       dz;
   logic       ends;

   word_t      lhs_mag;
   word_t      rhs_mag;
   word_t      q_fin;
   word_t      r_fin;
   logic [32:0] trial;

`ifdef DIVISION_SIGNED_EN
   logic qneg;
   logic rneg;

   div_sign_adjust u_lhs_abs (.val(bus.lhs), .neg(bus.lhs[31]), .res(lhs_mag));
   div_sign_adjust u_rhs_abs (.val(bus.rhs), .neg(bus.rhs[31]), .res(rhs_mag));
   div_sign_adjust u_q_fix   (.val(quot),    .neg(qneg),        .res(q_fin));
   div_sign_adjust u_r_fix   (.val(rem),     .neg(rneg),        .res(r_fin));

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         qneg <= 1'b0;
         rneg <= 1'b0;
      end else if (bus.state == DIV_INIT && bus.rhs != 32'd0) begin
         qneg <= bus.lhs[31] ^ bus.rhs[31];
         rneg <= bus.lhs[31];
      end
   end
`else
   assign lhs_mag = bus.lhs;
   assign rhs_mag = bus.rhs;
   assign q_fin   = quot;
   assign r_fin   = rem;
`endif

   // Top bit of the trial result is the borrow: set means restore.
   assign trial = {rem, dvd[31]} - {1'b0, dvs};

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         quot <= '0;
         rem  <= '0;
         dvd  <= '0;
         dvs  <= '0;
         cnt  <= '0;
         dz   <= 1'b0;
         ends <= 1'b1;
      end else begin
         case (bus.state)
            DIV_IDLE: ends <= 1'b1;
            DIV_INIT: begin
               ends <= 1'b0;
               if (bus.rhs == 32'd0) begin
                  quot <= 32'hFFFF_FFFF;
                  rem  <= bus.lhs;
                  dz   <= 1'b1;
                  cnt  <= DIV_DONE;
               end else begin
                  quot <= '0;
                  rem  <= '0;
                  dvd  <= lhs_mag;
                  dvs  <= rhs_mag;
                  dz   <= 1'b0;
                  cnt  <= '0;
               end
            end
            DIV_WORK: begin
               if (cnt < DIV_ITER) begin
                  if (!trial[32]) begin
                     rem  <= trial[31:0];
                     quot <= {quot[30:0], 1'b1};
                  end else begin
                     rem  <= {rem[30:0], dvd[31]};
                     quot <= {quot[30:0], 1'b0};
                  end
                  dvd  <= {dvd[30:0], 1'b0};
                  cnt  <= cnt + 6'd1;
                  ends <= 1'b0;
               end else if (cnt == DIV_ITER) begin
                  quot <= q_fin;
                  rem  <= r_fin;
                  cnt  <= DIV_DONE;
                  ends <= 1'b1;
               end else begin
                  ends <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient  = quot;
   assign bus.remainder = rem;
   assign bus.endSignal = ends;
   assign bus.divZero   = dz;
   assign bus.counter   = cnt;

endmodule

// File: tb/tb_division.sv
// Directed checks for division; expectations follow the build
// (DIVISION_SIGNED_EN selects signed results).
module tb_division;
   import mips_alu_pkg::*;

   logic Clk;
   logic reset;
   int   total;
   int   bad;

   division_if bus ();

   division dut (
      .Clk   (Clk),
      .reset (reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive at negedge, clock one rising edge, return at next negedge.
   task automatic step(input logic [5:0] s);
      bus.state = s;
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic init(input word_t a, input word_t b);
      bus.lhs = a;
      bus.rhs = b;
      step(DIV_INIT);
   endtask

   task automatic run(input word_t a, input word_t b);
      init(a, b);
      repeat (33) step(DIV_WORK);
   endtask

   task automatic result(input string tag, input word_t q, input word_t r);
      chk({tag, "_q"}, bus.quotient, q);
      chk({tag, "_r"}, bus.remainder, r);
      chk({tag, "_end"}, {31'd0, bus.endSignal}, 32'd1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.state = DIV_IDLE;
      bus.lhs = '0;
      bus.rhs = '0;
      @(negedge Clk);
      chk("rst_q", bus.quotient, 32'd0);
      chk("rst_r", bus.remainder, 32'd0);
      chk("rst_cnt", {26'd0, bus.counter}, 32'd0);
      chk("rst_end", {31'd0, bus.endSignal}, 32'd1);
      chk("rst_dz", {31'd0, bus.divZero}, 32'd0);
      reset = 1'b0;
      step(DIV_IDLE);

      init(32'd100, 32'd7);
      chk("init_end", {31'd0, bus.endSignal}, 32'd0);
      chk("init_cnt", {26'd0, bus.counter}, 32'd0);
      for (int i = 1; i <= 32; i++) begin
         step(DIV_WORK);
         chk($sformatf("busy%0d", i), {31'd0, bus.endSignal}, 32'd0);
      end
      chk("cnt32", {26'd0, bus.counter}, 32'd32);
      step(DIV_WORK);
      result("d100_7", 32'd14, 32'd2);
      chk("cnt33", {26'd0, bus.counter}, 32'd33);
      step(DIV_WORK);
      result("hold", 32'd14, 32'd2);
      step(DIV_IDLE);
      result("idle", 32'd14, 32'd2);

      run(32'hFFFF_FFFF, 32'd1);
      result("max_1", 32'hFFFF_FFFF, 32'd0);

      init(32'd5, 32'd0);
      chk("dz_flag", {31'd0, bus.divZero}, 32'd1);
      chk("dz_cnt", {26'd0, bus.counter}, 32'd33);
      chk("dz_busy", {31'd0, bus.endSignal}, 32'd0);
      step(DIV_WORK);
      result("dz", 32'hFFFF_FFFF, 32'd5);

      run(32'hFFFF_FFF9, 32'd2);
`ifdef DIVISION_SIGNED_EN
      result("m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
`else
      result("m7_2", 32'h7FFF_FFFC, 32'd1);
`endif

      run(32'h8000_0000, 32'hFFFF_FFFF);
      chk("ovf_dz", {31'd0, bus.divZero}, 32'd0);
`ifdef DIVISION_SIGNED_EN
      result("ovf", 32'h8000_0000, 32'd0);
`else
      result("ovf", 32'd0, 32'h8000_0000);
`endif

      init(32'd1000, 32'd3);
      step(6'd5);
      step(6'd5);
      chk("other_cnt", {26'd0, bus.counter}, 32'd0);
      chk("other_end", {31'd0, bus.endSignal}, 32'd0);
      repeat (9) step(DIV_WORK);
      bus.state = DIV_WORK;
      @(posedge Clk);
      #1 reset = 1'b1;
      #1;
      chk("mrst_q", bus.quotient, 32'd0);
      chk("mrst_r", bus.remainder, 32'd0);
      chk("mrst_cnt", {26'd0, bus.counter}, 32'd0);
      chk("mrst_end", {31'd0, bus.endSignal}, 32'd1);
      @(negedge Clk);
      reset = 1'b0;
      step(DIV_IDLE);

      init(32'd1000, 32'd3);
      repeat (10) step(DIV_WORK);
      chk("mid_cnt", {26'd0, bus.counter}, 32'd10);
      run(32'd12345, 32'd100);
      result("reinit", 32'd123, 32'd45);

      run(32'hDEAD_BEEF, 32'h0001_0000);
      result("shift16", 32'h0000_DEAD, 32'h0000_BEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
